// File: rtl/parity_check_rx.sv
// Receive-side parity checker with a 2-entry skid buffer.
// Incoming words are checked against the configured parity sense. They are
// queued in FIFO order with their parity-error tag and handed downstream
// without the parity bit. A saturating error counter and a sticky flag
// record every accepted word that has a bad parity bit.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_EMPTY | no words buffered, OUT_VALID low
// S_ONE   | one word buffered in the head slot
// S_TWO   | both slots full, IN_READY held low for the next cycle
module parity_check_rx #(
    parameter int DATA_W   = 8,
    parameter bit PAR_ODD  = 1'b1,
    parameter bit DROP_ERR = 1'b0,
    parameter int CNT_W    = 8
) (
    input  logic              CLK,
    input  logic              RSTB,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic              IN_PAR,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic              OUT_PERR,
    input  logic              CLR_ERR,
    output logic [CNT_W-1:0]  ERR_CNT,
    output logic              ERR_STICKY
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } occ_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    occ_e              state_q, state_d;
    logic [DATA_W-1:0] head_data_q, head_data_d;
    logic              head_perr_q, head_perr_d;
    logic [DATA_W-1:0] tail_data_q, tail_data_d;
    logic              tail_perr_q, tail_perr_d;
    logic              in_ready_q, in_ready_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic              err_sticky_q, err_sticky_d;

    logic perr;
    logic accept;
    logic push;
    logic pop;
    logic push_perr;

    // Handshake qualifiers; a bad word in drop mode is accepted but never stored.
    always_comb begin
        perr      = ((^{IN_DATA, IN_PAR}) != PAR_ODD);
        accept    = IN_VALID & in_ready_q;
        push      = accept & ~(DROP_ERR & perr);
        pop       = (state_q != S_EMPTY) & OUT_READY;
        push_perr = perr & ~DROP_ERR;
    end

    // Occupancy FSM and slot steering; the head slot always drives the outputs.
    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_perr_d = head_perr_q;
        tail_data_d = tail_data_q;
        tail_perr_d = tail_perr_q;
        case (state_q)
            S_EMPTY: begin
                if (push) begin
                    state_d     = S_ONE;
                    head_data_d = IN_DATA;
                    head_perr_d = push_perr;
                end
            end
            S_ONE: begin
                case ({push, pop})
                    2'b10: begin
                        state_d     = S_TWO;
                        tail_data_d = IN_DATA;
                        tail_perr_d = push_perr;
                    end
                    2'b11: begin
                        head_data_d = IN_DATA;
                        head_perr_d = push_perr;
                    end
                    2'b01: state_d = S_EMPTY;
                    default: state_d = S_ONE;
                endcase
            end
            S_TWO: begin
                // IN_READY was low, so no push can arrive here.
                if (pop) begin
                    state_d     = S_ONE;
                    head_data_d = tail_data_q;
                    head_perr_d = tail_perr_q;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        in_ready_d = (state_d != S_TWO);
    end

    // Error bookkeeping; a clear never swallows an error arriving in the same cycle.
    always_comb begin
        err_cnt_d    = err_cnt_q;
        err_sticky_d = err_sticky_q;
        if (accept && perr) begin
            err_sticky_d = 1'b1;
            if (CLR_ERR) begin
                err_cnt_d = CNT_W'(1);
            end else if (err_cnt_q != CNT_MAX) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
        end else if (CLR_ERR) begin
            err_cnt_d    = '0;
            err_sticky_d = 1'b0;
        end
    end

    // State register with immediate reset; reset discards any buffered words.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q      <= S_EMPTY;
            head_data_q  <= '0;
            head_perr_q  <= 1'b0;
            tail_data_q  <= '0;
            tail_perr_q  <= 1'b0;
            in_ready_q   <= 1'b1;
            err_cnt_q    <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            head_data_q  <= head_data_d;
            head_perr_q  <= head_perr_d;
            tail_data_q  <= tail_data_d;
            tail_perr_q  <= tail_perr_d;
            in_ready_q   <= in_ready_d;
            err_cnt_q    <= err_cnt_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    // All outputs come straight from registers.
    always_comb begin
        IN_READY   = in_ready_q;
        OUT_VALID  = (state_q != S_EMPTY);
        OUT_DATA   = head_data_q;
        OUT_PERR   = head_perr_q;
        ERR_CNT    = err_cnt_q;
        ERR_STICKY = err_sticky_q;
    end

endmodule

// File: tb/tb_parity_check_rx.sv
// Bench for parity_check_rx: a forwarding instance (8-bit counter) and a
// drop-mode instance (2-bit counter) share the upstream inputs. Each is
// compared every cycle against a queue-based reference model.
module tb_parity_check_rx;

    logic       clk;
    logic       rstb;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_par;
    logic       out_ready;
    logic       clr_err;

    logic       a_in_ready, a_out_valid, a_out_perr, a_sticky;
    logic [7:0] a_out_data, a_err_cnt;
    logic       b_in_ready, b_out_valid, b_out_perr, b_sticky;
    logic [7:0] b_out_data;
    logic [1:0] b_err_cnt;

    int errors = 0;
    int checks = 0;

    // model state: {perr, data} entries
    logic [8:0] qa[$];
    logic [8:0] qb[$];
    int  cnta, cntb;
    bit  sta, stb, rdya, rdyb;

    parity_check_rx #(.DATA_W(8), .PAR_ODD(1'b1), .DROP_ERR(1'b0), .CNT_W(8)) u_fwd (
        .CLK(clk), .RSTB(rstb), .IN_VALID(in_valid), .IN_READY(a_in_ready),
        .IN_DATA(in_data), .IN_PAR(in_par), .OUT_VALID(a_out_valid), .OUT_READY(out_ready),
        .OUT_DATA(a_out_data), .OUT_PERR(a_out_perr), .CLR_ERR(clr_err),
        .ERR_CNT(a_err_cnt), .ERR_STICKY(a_sticky)
    );

    parity_check_rx #(.DATA_W(8), .PAR_ODD(1'b1), .DROP_ERR(1'b1), .CNT_W(2)) u_drop (
        .CLK(clk), .RSTB(rstb), .IN_VALID(in_valid), .IN_READY(b_in_ready),
        .IN_DATA(in_data), .IN_PAR(in_par), .OUT_VALID(b_out_valid), .OUT_READY(out_ready),
        .OUT_DATA(b_out_data), .OUT_PERR(b_out_perr), .CLR_ERR(clr_err),
        .ERR_CNT(b_err_cnt), .ERR_STICKY(b_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        qa.delete();
        qb.delete();
        cnta = 0; cntb = 0;
        sta = 0; stb = 0;
        rdya = 1; rdyb = 1;
    endtask

    task automatic check_all();
        chk("a_in_ready", 32'(a_in_ready), 32'(rdya));
        chk("a_out_valid", 32'(a_out_valid), 32'(qa.size() > 0));
        if (qa.size() > 0) begin
            chk("a_out_data", 32'(a_out_data), 32'(qa[0][7:0]));
            chk("a_out_perr", 32'(a_out_perr), 32'(qa[0][8]));
        end
        chk("a_err_cnt", 32'(a_err_cnt), 32'(cnta));
        chk("a_sticky", 32'(a_sticky), 32'(sta));
        chk("b_in_ready", 32'(b_in_ready), 32'(rdyb));
        chk("b_out_valid", 32'(b_out_valid), 32'(qb.size() > 0));
        if (qb.size() > 0) begin
            chk("b_out_data", 32'(b_out_data), 32'(qb[0][7:0]));
            chk("b_out_perr", 32'(b_out_perr), 32'(qb[0][8]));
        end
        chk("b_err_cnt", 32'(b_err_cnt), 32'(cntb));
        chk("b_sticky", 32'(b_sticky), 32'(stb));
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_a_in_ready"}, 32'(a_in_ready), 32'd1);
        chk({tag, "_a_out_valid"}, 32'(a_out_valid), 32'd0);
        chk({tag, "_a_out_data"}, 32'(a_out_data), 32'd0);
        chk({tag, "_a_out_perr"}, 32'(a_out_perr), 32'd0);
        chk({tag, "_a_err_cnt"}, 32'(a_err_cnt), 32'd0);
        chk({tag, "_a_sticky"}, 32'(a_sticky), 32'd0);
        chk({tag, "_b_out_valid"}, 32'(b_out_valid), 32'd0);
        chk({tag, "_b_err_cnt"}, 32'(b_err_cnt), 32'd0);
    endtask

    // One clock: drive inputs, predict with the model, advance, compare.
    task automatic cycle(input bit v, input logic [7:0] d, input bit p, input bit ordy,
                         input bit clr, output bit acc_a);
        bit bad, acc_b, pop_a, pop_b;
        in_valid  = v;
        in_data   = d;
        in_par    = p;
        out_ready = ordy;
        clr_err   = clr;
        bad   = ((^{d, p}) != 1'b1);
        acc_a = v && rdya;
        acc_b = v && rdyb;
        pop_a = (qa.size() > 0) && ordy;
        pop_b = (qb.size() > 0) && ordy;
        @(posedge clk);
        #1;
        if (pop_a) void'(qa.pop_front());
        if (acc_a) qa.push_back({bad, d});
        if (pop_b) void'(qb.pop_front());
        if (acc_b && !bad) qb.push_back({1'b0, d});
        if (acc_a && bad) begin
            cnta = clr ? 1 : ((cnta < 255) ? cnta + 1 : 255);
            sta  = 1;
        end else if (clr) begin
            cnta = 0; sta = 0;
        end
        if (acc_b && bad) begin
            cntb = clr ? 1 : ((cntb < 3) ? cntb + 1 : 3);
            stb  = 1;
        end else if (clr) begin
            cntb = 0; stb = 0;
        end
        rdya = (qa.size() < 2);
        rdyb = (qb.size() < 2);
        check_all();
    endtask

    initial begin
        bit         acc;
        bit         fault;
        logic [7:0] wd;
        int         accepted;
        int         faults;

        rstb = 1'b0; in_valid = 0; in_data = 0; in_par = 0; out_ready = 0; clr_err = 0;
        model_reset();
        @(posedge clk); #1;
        reset_vals("por");
        rstb = 1'b1;
        cycle(0, 8'h00, 0, 1, 0, acc);

        // traffic plus an error, then reset mid-transfer
        cycle(1, 8'h01, 1, 0, 0, acc);
        cycle(1, 8'h5A, 1, 0, 0, acc);
        cycle(1, 8'h77, 0, 0, 0, acc);
        in_valid = 1;
        rstb = 1'b0;
        #1;
        reset_vals("midrst");
        model_reset();
        @(posedge clk); #1;
        rstb = 1'b1;
        cycle(0, 8'h00, 0, 1, 0, acc);

        // pass-through, odd parity
        cycle(1, 8'hA5, 1, 1, 0, acc);
        cycle(1, 8'h3C, 1, 1, 0, acc);
        cycle(0, 8'h00, 0, 1, 0, acc);
        cycle(0, 8'h00, 0, 1, 0, acc);

        // backpressure: third word held off until downstream drains
        cycle(1, 8'h11, 1, 0, 0, acc);
        cycle(1, 8'h22, 1, 0, 0, acc);
        chk("bp_full_ready", 32'(a_in_ready), 32'd0);
        cycle(1, 8'h33, 1, 0, 0, acc);
        chk("bp_held_off", 32'(acc), 32'd0);
        acc = 0;
        for (int i = 0; i < 10 && !acc; i++) cycle(1, 8'h33, 1, 1, 0, acc);
        chk("bp_third_accepted", 32'(acc), 32'd1);
        for (int i = 0; i < 4; i++) cycle(0, 8'h00, 0, 1, 0, acc);

        // error tag: forwarded on one instance, dropped on the other
        cycle(1, 8'h01, 1, 1, 0, acc);
        chk("perr_tag", 32'(a_out_perr), 32'd1);
        chk("drop_nothing_out", 32'(b_out_valid), 32'd0);
        cycle(0, 8'h00, 0, 1, 0, acc);

        // saturation of the 2-bit counter, then clear racing an error
        cycle(0, 8'h00, 0, 1, 1, acc);
        for (int i = 0; i < 5; i++) cycle(1, 8'h01, 1, 1, 0, acc);
        chk("sat_b_cnt", 32'(b_err_cnt), 32'd3);
        cycle(1, 8'h01, 1, 1, 1, acc);
        chk("clr_race_cnt", 32'(b_err_cnt), 32'd1);
        cycle(0, 8'h00, 0, 1, 1, acc);
        chk("clr_alone_sticky", 32'(b_sticky), 32'd0);

        // random stream with 1-in-4 parity faults and toggling downstream ready
        accepted = 0;
        faults = 0;
        wd = 8'($urandom);
        fault = ($urandom_range(0, 3) == 0);
        for (int c = 0; c < 3000 && accepted < 256; c++) begin
            cycle(1, wd, (~(^wd)) ^ fault, 1'($urandom_range(0, 1)), 0, acc);
            if (acc) begin
                accepted++;
                if (fault) faults++;
                wd = 8'($urandom);
                fault = ($urandom_range(0, 3) == 0);
            end
        end
        chk("stream_done", 32'(accepted), 32'd256);
        for (int i = 0; i < 4; i++) cycle(0, 8'h00, 0, 1, 0, acc);
        chk("stream_err_total", 32'(a_err_cnt), 32'((faults > 255) ? 255 : faults));
        chk("stream_drained", 32'(a_out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
